pixel_streamer: RTL and testbench

Host-side image source for the MNIST accelerator core. It buffers one full image of pixels written by the host, then streams the pixels back-to-back into the core's serial pixel input. It waits for the core's prediction, latches the digit, and reports completion. It sits directly in front of `core`, driving `i_valid`/`pixel`, and consumes `o_valid`/`digit`.

---
 rtl/pixel_streamer_pkg.sv | 32 +++
 rtl/pixel_frame_ram.sv | 44 ++++
 rtl/pixel_streamer.sv | 198 +++++++++++++++++++
 tb/tb_pixel_streamer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_streamer_pkg.sv
// -----------------------------------------------------------------------------
// pixel_streamer_pkg
//   Shared types and constants for the pixel_streamer block and its frame RAM.
//   - ps_state_t    : streamer FSM states (LOAD, FULL, STREAM, WAIT, DONE)
//   - DIGIT_WIDTH   : width of the core's predicted digit
//   - DIGIT_INVALID : digit reported when a result times out
//   - ps_width()    : address/counter width helper that never returns 0
//   Default pixel width and image size match the core configuration
//   (8-bit pixels, 784 pixels per image).
// -----------------------------------------------------------------------------
package pixel_streamer_pkg;

  localparam int PS_DEFAULT_DATA_WIDTH = 8;
  localparam int PS_DEFAULT_NUM_PIXELS = 784;

  localparam int                     DIGIT_WIDTH   = 4;
  localparam logic [DIGIT_WIDTH-1:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    FULL   = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } ps_state_t;

  // Width needed to index n items; a 1-entry range still gets one bit.
  function automatic int ps_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_ram.sv
// -----------------------------------------------------------------------------
// pixel_frame_ram
//   One image worth of pixel storage: simple dual-port, one write port and one
//   synchronous-read port, NUM_PIXELS x DATA_WIDTH, written so that synthesis
//   maps it onto block RAM.
//   Ports:
//     clk   in   clock
//     we    in   write enable
//     waddr in   write address
//     wdata in   write data
//     re    in   read enable (rdata updates on the next edge)
//     raddr in   read address
//     rdata out  registered read data, holds when re is low
// -----------------------------------------------------------------------------
module pixel_frame_ram
  import pixel_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = PS_DEFAULT_DATA_WIDTH,
  parameter int NUM_PIXELS = PS_DEFAULT_NUM_PIXELS,
  parameter int ADDR_WIDTH = ps_width(NUM_PIXELS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_PIXELS];

  // NOTE: the array has no reset on purpose; a reset loop over every entry
  // would stop the tools from mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_streamer.sv
// -----------------------------------------------------------------------------
// pixel_streamer
//   Host-side image source for the MNIST core. Buffers one image written by the
//   host, streams it back-to-back into the core's serial pixel input, waits
//   for the prediction (or a timeout) and reports the latched digit.
//
//   Ports:
//     clk        in   single clock
//     rst        in   synchronous active-high reset
//     wr_valid   in   host pixel write strobe
//     wr_data    in   host pixel
//     wr_ready   out  buffer accepts a write this cycle (LOAD or DONE)
//     start      in   stream the buffered image (FULL or DONE)
//     o_valid    out  pixel valid to core i_valid
//     pixel      out  pixel to core, holds when o_valid is low
//     res_valid  in   core result strobe (core o_valid)
//     res_digit  in   core predicted digit
//     busy       out  registered STREAM/WAIT indicator
//     done       out  result available
//     timeout    out  last result ended by timeout
//     digit      out  latched prediction
//
//   Build option PIXEL_STREAMER_LOOP_EN: when defined, DONE issues its own
//   start on its first cycle so the image streams continuously and done
//   pulses once per result; a host write in DONE still wins and stops looping.
// -----------------------------------------------------------------------------
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int DATA_WIDTH     = PS_DEFAULT_DATA_WIDTH,
  parameter int NUM_PIXELS     = PS_DEFAULT_NUM_PIXELS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  pixel,
  input  logic                   res_valid,
  input  logic [DIGIT_WIDTH-1:0] res_digit,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [DIGIT_WIDTH-1:0] digit
);

  localparam int PTR_W = ps_width(NUM_PIXELS);
  localparam int CNT_W = ps_width(TIMEOUT_CYCLES);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  ps_state_t             state;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  rd_valid;   // RAM output holds a pixel this cycle
  logic [DATA_WIDTH-1:0] rd_data;

  logic wr_accept;
  logic wr_last;
  logic rd_en;
  logic start_eff;
  logic wait_counting;

  assign wr_ready  = (state == LOAD) || (state == DONE);
  assign wr_accept = wr_valid && wr_ready;
  assign wr_last   = (wr_ptr == LAST_IDX);
  assign rd_en     = (state == STREAM);

`ifdef PIXEL_STREAMER_LOOP_EN
  // DONE never lingers: it restarts on its first cycle unless a write wins.
  assign start_eff = start || (state == DONE);
`else
  assign start_eff = start;
`endif

  // The timeout window opens only once the read pipeline has drained, i.e.
  // on the first cycle o_valid is low after the stream.
  assign wait_counting = (state == WAIT) && !rd_valid && !o_valid;

  pixel_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_WIDTH (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wait_cnt <= '0;
      rd_valid <= 1'b0;
      o_valid  <= 1'b0;
      pixel    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      digit    <= '0;
    end else begin
      // Two-stage read path: RAM register, then output register.
      rd_valid <= rd_en;
      o_valid  <= rd_valid;
      if (rd_valid) begin
        pixel <= rd_data;
      end

      busy <= (state == STREAM) || (state == WAIT);

      case (state)
        LOAD: begin
          if (wr_accept) begin
            if (wr_last) begin
              state  <= FULL;
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end

        FULL: begin
          if (start) begin
            state  <= STREAM;
            rd_ptr <= '0;
          end
        end

        STREAM: begin
          if (rd_ptr == LAST_IDX) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end else begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
        end

        WAIT: begin
          // A result on the terminal-count cycle takes priority over timeout.
          if (res_valid) begin
            digit   <= res_digit;
            done    <= 1'b1;
            timeout <= 1'b0;
            state   <= DONE;
          end else if (wait_counting) begin
            if (wait_cnt == LAST_CNT) begin
              digit   <= DIGIT_INVALID;
              done    <= 1'b1;
              timeout <= 1'b1;
              state   <= DONE;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          // wr_ptr is 0 here, so the write lands at index 0 and starts a new
          // image; a simultaneous start is dropped.
          if (wr_accept) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (wr_last) begin
              state  <= FULL;
              wr_ptr <= '0;
            end else begin
              state  <= LOAD;
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end else if (start_eff) begin
            done   <= 1'b0;
            state  <= STREAM;
            rd_ptr <= '0;
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// -----------------------------------------------------------------------------
// tb_pixel_streamer
//   Directed bench for pixel_streamer with NUM_PIXELS=784, DATA_WIDTH=8 and
//   TIMEOUT_CYCLES=16. Inputs change and outputs are sampled on the falling
//   edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_pixel_streamer;

  localparam int DW = 8;
  localparam int N  = 784;
  localparam int T  = 16;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          start;
  logic          o_valid;
  logic [DW-1:0] pixel;
  logic          res_valid;
  logic [3:0]    res_digit;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [3:0]    digit;

  logic [DW-1:0] model [N];

  int errors = 0;
  int checks = 0;

  pixel_streamer #(
    .DATA_WIDTH     (DW),
    .NUM_PIXELS     (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .start     (start),
    .o_valid   (o_valid),
    .pixel     (pixel),
    .res_valid (res_valid),
    .res_digit (res_digit),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .digit     (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pat_val(input int p, input int i);
    int v;
    v = (p == 0) ? i : (i * 3 + 1);
    return DW'(v % 256);
  endfunction

  // Writes a whole image while optionally holding res_valid high (ignored in LOAD).
  task automatic load_image(input int p, input bit res_noise);
    res_valid = res_noise;
    res_digit = 4'd9;
    for (int i = 0; i < N; i++) begin
      model[i] = pat_val(p, i);
      wr_valid = 1'b1;
      wr_data  = model[i];
      @(negedge clk);
    end
    wr_valid  = 1'b0;
    res_valid = 1'b0;
  endtask

  // Expects o_valid from edge k+2 through k+1+N (k = edge sampling start),
  // pixels in write order, then o_valid low with pixel held.
  task automatic run_stream(input bit use_start, input bit noise, input string tag);
    int bad;
    bad = 0;
    if (use_start) start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    res_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL %s_ovalid_k: got %b expected 0", tag, o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL %s_ovalid_k1: got %b expected 0", tag, o_valid);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy_k1: got %b expected 1", tag, busy);
    end
    for (int i = 0; i < N; i++) begin
      if (noise) begin
        res_valid = (i < 100);
        res_digit = 4'd9;
      end
      @(negedge clk);
      if (o_valid !== 1'b1 || pixel !== model[i]) begin
        if (bad < 4)
          $display("  pixel %0d: o_valid=%b pixel=%0d want %0d", i, o_valid, pixel, model[i]);
        bad++;
      end
    end
    res_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL %s_pixels: got %0d bad cycles expected 0", tag, bad);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL %s_tail: got o_valid=%b expected 0", tag, o_valid);
    end
    checks++;
    if (pixel !== model[N-1]) begin
      errors++; $display("FAIL %s_pixel_hold: got %0d expected %0d", tag, pixel, model[N-1]);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s_done_low: got %b expected 0", tag, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0;
    res_valid = 1'b0; res_digit = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++;
    if (pixel !== '0) begin errors++; $display("FAIL reset_pixel: got %0d expected 0", pixel); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_done_timeout: got %b%b expected 00", done, timeout);
    end
    checks++;
    if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_and_stream;
    load_image(0, 1'b1);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
    checks++;
    if (done !== 1'b0 || digit !== 4'd0) begin
      errors++; $display("FAIL load_res_ignored: got done=%b digit=%0d expected 0/0", done, digit);
    end
    run_stream(1'b1, 1'b1, "stream1");
  endtask

  task automatic test_result;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL result_pre_done: got %b expected 0", done); end
    res_valid = 1'b1; res_digit = 4'd7;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || digit !== 4'd7) begin
      errors++; $display("FAIL result_latch: got done=%b timeout=%b digit=%0d expected 1/0/7", done, timeout, digit);
    end
    res_digit = 4'd3;
`ifdef PIXEL_STREAMER_LOOP_EN
    run_stream(1'b0, 1'b0, "loop2");
    checks++;
    if (digit !== 4'd7) begin errors++; $display("FAIL result_second_ignored: got %0d expected 7", digit); end
`else
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (digit !== 4'd7 || done !== 1'b1) begin
      errors++; $display("FAIL result_second_ignored: got done=%b digit=%0d expected 1/7", done, digit);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_hold: got done=%b o_valid=%b busy=%b expected 1/0/0", done, o_valid, busy);
    end
`endif
  endtask

  task automatic test_loop;
    int pulses;
    repeat (2) @(negedge clk);
    res_valid = 1'b1; res_digit = 4'd5;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || digit !== 4'd5) begin
      errors++; $display("FAIL loop_result: got done=%b digit=%0d expected 1/5", done, digit);
    end
    pulses = 1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL loop_done_pulse: got %0d high cycles expected 1", pulses); end
    checks++;
    if (o_valid !== 1'b1 || pixel !== model[0]) begin
      errors++; $display("FAIL loop_third_stream: got o_valid=%b pixel=%0d expected 1/%0d", o_valid, pixel, model[0]);
    end
  endtask

  task automatic test_timeout;
    int bad;
    bad = 0;
    run_stream(1'b1, 1'b0, "restream");
    for (int i = 1; i < T; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL timeout_early: got %0d early done cycles expected 0", bad); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || digit !== 4'hF) begin
      errors++; $display("FAIL timeout_fire: got done=%b timeout=%b digit=%h expected 1/1/f", done, timeout, digit);
    end
  endtask

  task automatic test_write_start_collision;
    int seen;
    seen = 0;
    model[0] = 8'hAA;
    wr_valid = 1'b1; wr_data = 8'hAA; start = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0;
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL collision_state: got done=%b timeout=%b wr_ready=%b expected 0/0/1", done, timeout, wr_ready);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL collision_no_stream: got %0d active cycles expected 0", seen); end
    for (int i = 1; i < N; i++) begin
      model[i] = pat_val(0, i);
      if (i == N - 1) begin
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL collision_ptr_last: got wr_ready=%b expected 1", wr_ready); end
      end
      wr_valid = 1'b1; wr_data = model[i];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL collision_ptr_full: got wr_ready=%b expected 0", wr_ready); end
    run_stream(1'b1, 1'b0, "after_collision");
    @(negedge clk);
    res_valid = 1'b1; res_digit = 4'd2;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || digit !== 4'd2) begin
      errors++; $display("FAIL collision_result: got done=%b digit=%0d expected 1/2", done, digit);
    end
  endtask

  task automatic test_reset_mid_stream;
    int seen;
    int budget;
    seen = 0; budget = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (seen < 400 && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (o_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 400) begin errors++; $display("FAIL midstream_reach: got %0d pixels expected 400", seen); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midstream_reset: got o_valid=%b wr_ready=%b busy=%b expected 0/1/0", o_valid, wr_ready, busy);
    end
    checks++;
    if (done !== 1'b0 || digit !== 4'd0 || pixel !== '0) begin
      errors++; $display("FAIL midstream_reset_regs: got done=%b digit=%0d pixel=%0d expected 0/0/0", done, digit, pixel);
    end
    rst = 1'b0;
    @(negedge clk);
    load_image(1, 1'b0);
    run_stream(1'b1, 1'b1, "after_reset");
  endtask

  task automatic test_terminal_count_result;
    repeat (T - 1) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL terminal_pre: got done=%b expected 0", done); end
    res_valid = 1'b1; res_digit = 4'd4;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || digit !== 4'd4) begin
      errors++; $display("FAIL terminal_result_wins: got done=%b timeout=%b digit=%0d expected 1/0/4", done, timeout, digit);
    end
  endtask

  initial begin
    test_reset;
    test_load_and_stream;
    test_result;
`ifdef PIXEL_STREAMER_LOOP_EN
    test_loop;
    test_reset;
`else
    test_timeout;
    test_write_start_collision;
    test_reset_mid_stream;
    test_terminal_count_result;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
